// File: rtl/fp_add_share_arb_pkg.sv
// Shared types and constants for the FP adder sharing arbiter.
package fp_add_share_arb_pkg;

  localparam int unsigned FP_W            = 32;
  localparam int unsigned ADD_LATENCY_DEF = 3;
  localparam int unsigned TAG_ID_W        = 3;
  localparam int unsigned STAT_W          = 16;
  localparam logic [STAT_W-1:0] STAT_MAX  = '1;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/fp_add_share_arb_rr_arbiter.sv
// Round-robin picker: first requester at or above the pointer (with wrap),
// pointer advances past the winner only when a grant is issued.
module rr_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned ID_W = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            en,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_id
);

  logic [ID_W-1:0] ptr_q, idx, pick_id;
  logic [N-1:0]    pick;
  logic            found;
  int unsigned     s;

  always_comb begin
    pick    = '0;
    pick_id = '0;
    found   = 1'b0;
    idx     = '0;
    s       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      s = 32'(ptr_q) + k;
      if (s >= N) s = s - N;
      idx = ID_W'(s);
      if (!found && req[idx]) begin
        found     = 1'b1;
        pick[idx] = 1'b1;
        pick_id   = idx;
      end
    end
  end

  assign grant    = en ? pick : '0;
  assign grant_id = pick_id;

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else if (en && found) ptr_q <= (pick_id == ID_W'(N - 1)) ? '0 : pick_id + 1'b1;
  end

endmodule

// File: rtl/sp_add.sv
// Pipelined single-precision adder (DSP sp_add mode): round-to-nearest-even,
// denormals flushed to zero, synchronous clear of every pipeline register.
module sp_add #(
  parameter int unsigned PIPE = 3
) (
  input  logic        clk,
  input  logic        ena,
  input  logic        clr,
  input  logic [31:0] ax,
  input  logic [31:0] ay,
  output logic [31:0] result
);

  logic [31:0]       big, sml, sum_c;
  logic [7:0]        eb, es, d;
  logic [26:0]       mb, ms, ms_sh;
  logic [27:0]       acc;
  logic signed [9:0] e;
  logic              sub, rup;
  logic [24:0]       rnd;
  logic [31:0]       pipe_q [PIPE];

  // Align the smaller magnitude, add/subtract with guard/round/sticky, renormalise, round.
  always_comb begin
    big = ax;
    sml = ay;
    if (ax[30:0] < ay[30:0]) begin
      big = ay;
      sml = ax;
    end
    eb  = big[30:23];
    es  = sml[30:23];
    sub = big[31] ^ sml[31];
    mb  = (eb == 8'd0) ? 27'd0 : {1'b1, big[22:0], 3'b000};
    ms  = (es == 8'd0) ? 27'd0 : {1'b1, sml[22:0], 3'b000};
    d   = eb - es;
    if (d >= 8'd27) ms_sh = {26'd0, |ms};
    else ms_sh = (ms >> d) | {26'd0, |(ms & ((27'd1 << d) - 27'd1))};
    e = $signed({2'b00, eb});
    if (!sub) begin
      acc = {1'b0, mb} + {1'b0, ms_sh};
      if (acc[27]) begin
        acc = {1'b0, acc[27:2], acc[1] | acc[0]};
        e   = e + 10'sd1;
      end
    end else begin
      acc = {1'b0, mb} - {1'b0, ms_sh};
      for (int k = 0; k < 26; k++) begin
        if (!acc[26] && (acc != 28'd0)) begin
          acc = acc << 1;
          e   = e - 10'sd1;
        end
      end
    end
    rup = acc[2] & (acc[1] | acc[0] | acc[3]);
    rnd = {1'b0, acc[26:3]} + 25'(rup);
    if (rnd[24]) begin
      rnd = rnd >> 1;
      e   = e + 10'sd1;
    end
    if (eb == 8'hFF) begin
      if ((big[22:0] != 23'd0) || ((es == 8'hFF) && ((sml[22:0] != 23'd0) || sub)))
        sum_c = 32'h7FC0_0000;
      else
        sum_c = big;
    end else if (acc == 28'd0) begin
      sum_c = {big[31] & sml[31], 31'd0};
    end else if (e <= 10'sd0) begin
      sum_c = {big[31], 31'd0};
    end else if (e >= 10'sd255) begin
      sum_c = {big[31], 8'hFF, 23'd0};
    end else begin
      sum_c = {big[31], e[7:0], rnd[22:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < int'(PIPE); i++) pipe_q[i] <= '0;
    end else if (ena) begin
      pipe_q[0] <= sum_c;
      for (int i = 1; i < int'(PIPE); i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign result = pipe_q[PIPE-1];

endmodule

// File: rtl/fp_add_share_arb.sv
// Shares one pipelined FP adder among NUM_REQ requesters with tag-tracked results
// and a flush/drain sequencer. FP_ADD_SHARE_ARB_STATS_EN adds grant/stall counters.
module fp_add_share_arb
  import fp_add_share_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ADD_LATENCY = ADD_LATENCY_DEF,
  parameter int unsigned ID_W        = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*FP_W-1:0] req_a,
  input  logic [NUM_REQ*FP_W-1:0] req_b,
  output logic [NUM_REQ-1:0]      res_valid,
  output logic [FP_W-1:0]         res_data,
  output logic [ID_W-1:0]         res_id,
  input  logic                    flush,
  output logic                    flush_done,
  output logic                    busy
`ifdef FP_ADD_SHARE_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0] stat_grants,
  output logic [STAT_W-1:0]         stat_stall
`endif
);

  state_t              state_q, state_d;
  logic                grant_en, xfer;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_id;
  logic [FP_W-1:0]     ax, ay;
  tag_t                tag_q [ADD_LATENCY];

  // Flush wins over any request in the cycle it is first seen.
  assign grant_en = (state_q == ST_RUN) && !flush && !rst;

  rr_arbiter #(.N(NUM_REQ), .ID_W(ID_W)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (req_valid),
    .en       (grant_en),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign req_ready = grant;
  assign xfer      = |grant;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    flush_done = 1'b0;
    case (state_q)
      ST_RUN:   if (flush) state_d = ST_DRAIN;
      ST_DRAIN: if (!busy) state_d = ST_DONE;
      ST_DONE: begin
        flush_done = flush;
        if (!flush) state_d = ST_RUN;
      end
      default:  state_d = ST_RUN;
    endcase
  end

  // Idle cycles feed 0+0; the untagged result is dropped.
  always_comb begin
    ax = '0;
    ay = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant[i]) begin
        ax = req_a[FP_W*i +: FP_W];
        ay = req_b[FP_W*i +: FP_W];
      end
    end
  end

  sp_add #(.PIPE(ADD_LATENCY)) u_add (
    .clk    (clk),
    .ena    (1'b1),
    .clr    (rst),
    .ax     (ax),
    .ay     (ay),
    .result (res_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < int'(ADD_LATENCY); s++) tag_q[s] <= '0;
    end else begin
      tag_q[0] <= '{valid: xfer, id: TAG_ID_W'(grant_id)};
      for (int s = 1; s < int'(ADD_LATENCY); s++) tag_q[s] <= tag_q[s-1];
    end
  end

  always_comb begin
    res_valid = '0;
    busy      = 1'b0;
    for (int s = 0; s < int'(ADD_LATENCY); s++) busy = busy | tag_q[s].valid;
    if (tag_q[ADD_LATENCY-1].valid) res_valid[ID_W'(tag_q[ADD_LATENCY-1].id)] = 1'b1;
    res_id = ID_W'(tag_q[ADD_LATENCY-1].id);
  end

`ifdef FP_ADD_SHARE_ARB_STATS_EN
  logic [STAT_W-1:0] grant_cnt_q [NUM_REQ];
  logic [STAT_W-1:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REQ); i++) grant_cnt_q[i] <= '0;
      stall_q <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (grant[i] && (grant_cnt_q[i] != STAT_MAX)) grant_cnt_q[i] <= grant_cnt_q[i] + 1'b1;
      end
      if ((|req_valid) && !xfer && (stall_q != STAT_MAX)) stall_q <= stall_q + 1'b1;
    end
  end

  always_comb begin
    stat_grants = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) stat_grants[STAT_W*i +: STAT_W] = grant_cnt_q[i];
  end

  assign stat_stall = stall_q;
`endif

endmodule

// File: doc/fp_add_share_arb.md
Name: fp_add_share_arb

Overview:
- Time-multiplexes one single-precision pipelined FP adder (sp_add DSP mode, sync clear) among NUM_REQ requesters, e.g. per-cell force accumulation lanes.
- Round-robin arbitration with a valid/ready handshake on each requester port.
- A tag shift register tracks in-flight operations so each sum returns to the requester that issued it.
- A flush sequencer drains the pipeline before a phase change.

Parameters:
- NUM_REQ, 4, number of requester ports (2..8).
- ADD_LATENCY, 3, adder cycles from operand capture to result valid; must equal the adder instance pipeline depth.
- ID_W, $clog2(NUM_REQ), requester index width.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous reset, active-high; also drives the adder clr.
- req_valid  in  NUM_REQ  operand pair valid, one bit per requester.
- req_ready  out  NUM_REQ  one-hot grant; transfer when req_valid[i] & req_ready[i].
- req_a  in  NUM_REQ*32  operand A, requester i at bits [32*i+31:32*i].
- req_b  in  NUM_REQ*32  operand B, same packing.
- res_valid  out  NUM_REQ  one-hot, pulses one cycle when a sum is ready for that requester.
- res_data  out  32  IEEE-754 single-precision sum.
- res_id  out  ID_W  index of the requester owning res_data.
- flush  in  1  level request to stop granting and drain.
- flush_done  out  1  high while the pipeline is empty and flush is held.
- busy  out  1  at least one operation in flight.

Behaviour:
- Reset values: req_ready=0, res_valid=0, res_data=0, res_id=0, flush_done=0, busy=0, round-robin pointer=0, tag pipe cleared, FSM=RUN.
- Grant (RUN only):
  - Combinational grant to the first i with req_valid[i], searching from pointer upward with wrap.
  - req_ready is the one-hot grant, so at most one bit is high.
  - On a transfer, the pointer moves to (granted index + 1) mod NUM_REQ; with no transfer it holds.
  - A requester may hold req_valid across cycles. The arbiter never grants an idle port.
- Datapath:
  - The adder is instantiated with ena=1 and clr=rst.
  - The granted requester's operands drive ax/ay in the transfer cycle.
  - Idle cycles drive ax=ay=0; no tag is set, so the resulting 0.0 is discarded.
- Tag pipe:
  - ADD_LATENCY stages, each holding {valid, id}.
  - Stage 0 loads {transfer, granted id}.
  - Output stage: res_valid[id]=valid, res_id=id, res_data=adder result, all in the same cycle.
  - Latency is exactly ADD_LATENCY cycles from transfer to res_valid.
  - Throughput is one operation per cycle, with no output backpressure; requesters must always accept results.
- busy = OR of all tag valid bits.
- FSM:
  - RUN: granting. If flush=1 go to DRAIN; no grant in the cycle flush is first seen.
  - DRAIN: req_ready=0. Go to DONE when busy=0.
  - DONE: flush_done=1. When flush drops, return to RUN the next cycle. The pointer is preserved.
- Simultaneous events:
  - flush and req_valid in the same cycle: flush wins, no grant.
  - In-flight results during DRAIN are still delivered.
- rst mid-operation: the tag pipe is cleared, in-flight results are discarded (no res_valid), FSM returns to RUN.
- Arithmetic (rounding, denormals, specials) is the adder's behaviour; the arbiter passes the 32-bit result unaltered.

Optional Feature:
- Macro: FP_ADD_SHARE_ARB_STATS_EN.
- Defined:
  - Adds output stat_grants, NUM_REQ*16 bits: per-requester saturating grant counters.
  - Adds output stat_stall, 16 bits: saturating count of cycles with req_valid!=0 and no grant (DRAIN/DONE or losers).
  - All counters cleared by rst. Saturate at 0xFFFF.
- Undefined: no ports or logic added; behaviour otherwise identical.

Decomposition:
- Shared package: FP_W=32, ADD_LATENCY default constant, tag struct {valid, id}, FSM enum {RUN, DRAIN, DONE}.
- One natural sub-module, rr_arbiter: a parameterised combinational round-robin picker plus a pointer register. It is reusable by other shared DSP controllers.
- The adder is a child instance and is not re-implemented.

Test Plan:
- Single request: req 0 sends 0x3F800000 + 0x40000000 (1.0+2.0). Expect res_valid=0001, res_id=0, res_data=0x40400000 exactly 3 cycles after the transfer.
- All four requesters valid continuously from pointer 0: grants follow 0,1,2,3,0,...; results return in the same order, one per cycle; each returns its own sum, e.g. req i sends i+1.0 plus 1.0.
- Sparse: only req 2 and req 0 valid with pointer=1. Expect grant order 2,0,2, and no grant to idle ports.
- Flush: flush held while 3 ops are in flight. req_ready=0 from the first flush cycle; all 3 results are delivered; flush_done=1 the cycle after busy falls; dropping flush resumes granting from the saved pointer.
- Reset mid-flight: issue 2 ops, assert rst for 1 cycle before the results. Expect no res_valid ever for them, busy=0, and all outputs at reset values.
- Stats (macro defined): 10 grants to req 1 and 5 stall cycles. Expect stat_grants[31:16]=10 and stat_stall=5; confirm saturation at 0xFFFF.
